// File: rtl/i2c_req_arbiter_if.sv
// Requester and I2C-master bundle for i2c_req_arbiter.
// slave  : view used by the arbiter (samples requests and master status,
//          drives grant/response and the master command).
// master : view used by whatever drives the arbiter (requesters + I2C master).
// Signals:
//   req/req_addr0/req_addr1/req_rw/req_wdata0/req_wdata1 : requester payloads
//   grant, rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout : requester side
//   m_start, m_addr, m_rw, m_wdata, m_abort : command to the I2C master
//   m_busy, m_done, m_nack, m_rdata          : I2C master status
interface i2c_req_arbiter_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREQ   = 2;

  logic [NREQ-1:0]   req;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [NREQ-1:0]   req_rw;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;

  logic [NREQ-1:0]   grant;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              m_start;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [DATA_W-1:0] m_wdata;
  logic              m_abort;
  logic              m_busy;
  logic              m_done;
  logic              m_nack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  req, req_addr0, req_addr1, req_rw, req_wdata0, req_wdata1,
    input  m_busy, m_done, m_nack, m_rdata,
    output grant, rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    output m_start, m_addr, m_rw, m_wdata, m_abort
  );

  modport master (
    output req, req_addr0, req_addr1, req_rw, req_wdata0, req_wdata1,
    output m_busy, m_done, m_nack, m_rdata,
    input  grant, rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    input  m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin arbiter and single-byte transaction sequencer
// in front of the shared I2C master.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : i2c_req_arbiter_if.slave (requests, grant/response, master cmd/status)
// Build option: define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT_CYCLES clocks (legal 2..65535) that aborts the master and reports
// rsp_timeout. Without it m_abort and rsp_timeout are constant 0.
module i2c_req_arbiter
`ifdef I2C_ARB_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
  )
`endif
  (
    input logic              clk,
    input logic              reset_n,
    i2c_req_arbiter_if.slave bus
  );

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREQ   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic              last_id;
  logic              win_id;
  logic              win_c;

  logic [NREQ-1:0]   grant_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              m_start_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic              m_rw_q;
  logic [DATA_W-1:0] m_wdata_q;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = 16;
  // Compare one early so m_abort is registered on the cycle the count hits TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES - 2);

  logic [WD_W-1:0]   wd_cnt;
  logic              m_abort_q;
  logic              rsp_timeout_q;
`endif

  // Winner: sole requester, otherwise the one that did not go last.
  always_comb begin
    win_c = 1'b0;
    case (bus.req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      default: win_c = ~last_id;
    endcase
  end

  // Sequencer: arbitration, payload latch, master handshake, response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      last_id     <= 1'b1;
      win_id      <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      m_start_q   <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_wdata_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      m_abort_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      m_start_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      m_abort_q   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|bus.req) state <= S_ARB;
        end
        S_ARB: begin
          if (|bus.req) begin
            win_id    <= win_c;
            grant_q   <= win_c ? 2'b10 : 2'b01;
            m_addr_q  <= win_c ? bus.req_addr1 : bus.req_addr0;
            m_wdata_q <= win_c ? bus.req_wdata1 : bus.req_wdata0;
            m_rw_q    <= bus.req_rw[win_c];
            state     <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!bus.m_busy) begin
            m_start_q <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (m_abort_q) begin
            // Abort went out last cycle; report the timeout now.
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= win_id;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= S_RESP;
          end else if (bus.m_done) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= win_id;
            rsp_rdata_q   <= m_rw_q ? bus.m_rdata : '0;
            rsp_err_q     <= bus.m_nack;
            rsp_timeout_q <= 1'b0;
            state         <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_TERM) m_abort_q <= 1'b1;
          end
`else
          if (bus.m_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_id;
            rsp_rdata_q <= m_rw_q ? bus.m_rdata : '0;
            rsp_err_q   <= bus.m_nack;
            state       <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          grant_q <= '0;
          last_id <= win_id;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.m_wdata   = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.m_abort     = m_abort_q;
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.m_abort     = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; cycle numbers in tags count from the
// cycle in which req is raised.
module tb_i2c_req_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_asserts = 0;
  int   n_fail    = 0;

  i2c_req_arbiter_if bus ();

`ifdef I2C_ARB_TIMEOUT_EN
  i2c_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`else
  i2c_req_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`endif

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle m_done with status; returns in the rsp_valid cycle.
  task automatic pulse_done(input logic nack, input logic [7:0] rdata);
    bus.m_done  = 1'b1;
    bus.m_nack  = nack;
    bus.m_rdata = rdata;
    tick();
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req        = 2'b00;
    bus.req_addr0  = 7'h00;
    bus.req_addr1  = 7'h00;
    bus.req_rw     = 2'b00;
    bus.req_wdata0 = 8'h00;
    bus.req_wdata1 = 8'h00;
    bus.m_busy     = 1'b0;
    bus.m_done     = 1'b0;
    bus.m_nack     = 1'b0;
    bus.m_rdata    = 8'h00;
    tick(2);

    // Reset values
    chk("rst_grant",     32'(bus.grant), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_m_start",   32'(bus.m_start), 32'h0);
    chk("rst_m_abort",   32'(bus.m_abort), 32'h0);
    chk("rst_m_addr",    32'(bus.m_addr), 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Stray m_done while idle is ignored
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    chk("stray_done_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Single write from requester 0, done 20 cycles after start
    bus.req_addr0  = 7'h50;
    bus.req_rw     = 2'b00;
    bus.req_wdata0 = 8'hA5;
    bus.req        = 2'b01;
    tick();
    chk("wr_c1_grant", 32'(bus.grant), 32'h0);
    tick();
    chk("wr_c2_grant", 32'(bus.grant), 32'h1);
    chk("wr_c2_m_start", 32'(bus.m_start), 32'h0);
    bus.req_wdata0 = 8'h00;
    tick();
    chk("wr_c3_m_start", 32'(bus.m_start), 32'h1);
    chk("wr_c3_m_addr",  32'(bus.m_addr), 32'h50);
    chk("wr_c3_m_wdata", 32'(bus.m_wdata), 32'hA5);
    chk("wr_c3_m_rw",    32'(bus.m_rw), 32'h0);
    tick();
    chk("wr_c4_m_start", 32'(bus.m_start), 32'h0);
    tick(19);
    pulse_done(1'b0, 8'hFF);
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("wr_rsp_id",    32'(bus.rsp_id), 32'h0);
    chk("wr_rsp_err",   32'(bus.rsp_err), 32'h0);
    chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
    chk("wr_rsp_grant", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    tick();
    chk("wr_grant_clr",     32'(bus.grant), 32'h0);
    chk("wr_rsp_valid_clr", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Read with NACK from requester 1
    bus.req_addr1  = 7'h1D;
    bus.req_rw     = 2'b10;
    bus.req_wdata1 = 8'h77;
    bus.req        = 2'b10;
    tick(3);
    chk("rd_m_start", 32'(bus.m_start), 32'h1);
    chk("rd_grant",   32'(bus.grant), 32'h2);
    chk("rd_m_addr",  32'(bus.m_addr), 32'h1D);
    chk("rd_m_rw",    32'(bus.m_rw), 32'h1);
    tick(2);
    pulse_done(1'b1, 8'h5A);
    chk("rd_rsp_valid",   32'(bus.rsp_valid), 32'h1);
    chk("rd_rsp_id",      32'(bus.rsp_id), 32'h1);
    chk("rd_rsp_err",     32'(bus.rsp_err), 32'h1);
    chk("rd_rsp_rdata",   32'(bus.rsp_rdata), 32'h5A);
    chk("rd_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    bus.req = 2'b00;
    tick(2);

    // Round-robin with both requesting; requester 1 went last
    bus.req_addr0 = 7'h11;
    bus.req_addr1 = 7'h22;
    bus.req_rw    = 2'b00;
    bus.req       = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        tick(2);
      end else begin
        tick();
        chk("rr_gap_grant", 32'(bus.grant), 32'h0);
        tick(2);
      end
      chk("rr_grant",   32'(bus.grant), (i % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      chk("rr_m_start", 32'(bus.m_start), 32'h1);
      chk("rr_m_addr",  32'(bus.m_addr), (i % 2 == 1) ? 32'h22 : 32'h11);
      tick();
      pulse_done(1'b0, 8'h00);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("rr_rsp_id",    32'(bus.rsp_id), 32'(i % 2));
    end
    bus.req = 2'b00;
    tick(2);

    // Busy stall: m_busy high for the first 10 ISSUE cycles
    bus.req    = 2'b01;
    bus.m_busy = 1'b1;
    tick(2);
    for (int j = 0; j < 10; j++) begin
      chk("busy_m_start", 32'(bus.m_start), 32'h0);
      chk("busy_grant",   32'(bus.grant), 32'h1);
      tick();
    end
    bus.m_busy = 1'b0;
    chk("busy_fall_m_start", 32'(bus.m_start), 32'h0);
    tick();
    chk("busy_after_m_start", 32'(bus.m_start), 32'h1);
    chk("busy_after_grant",   32'(bus.grant), 32'h1);
    tick();
    pulse_done(1'b0, 8'h00);
    chk("busy_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    bus.req = 2'b00;
    tick(2);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog expiry with TIMEOUT_CYCLES=16: abort at start+15, response next
    bus.req_rw = 2'b01;
    bus.req    = 2'b01;
    tick(3);
    chk("to_m_start", 32'(bus.m_start), 32'h1);
    tick(14);
    chk("to_pre_abort", 32'(bus.m_abort), 32'h0);
    tick();
    chk("to_m_abort",        32'(bus.m_abort), 32'h1);
    chk("to_abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("to_rsp_valid",   32'(bus.rsp_valid), 32'h1);
    chk("to_rsp_err",     32'(bus.rsp_err), 32'h1);
    chk("to_rsp_timeout", 32'(bus.rsp_timeout), 32'h1);
    chk("to_rsp_rdata",   32'(bus.rsp_rdata), 32'h00);
    chk("to_abort_clr",   32'(bus.m_abort), 32'h0);
    bus.req = 2'b00;
    tick(2);

    // m_done on the terminal cycle wins over the watchdog
    bus.req = 2'b01;
    tick(3);
    chk("tod_m_start", 32'(bus.m_start), 32'h1);
    tick(14);
    pulse_done(1'b0, 8'h3C);
    chk("tod_rsp_valid",   32'(bus.rsp_valid), 32'h1);
    chk("tod_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    chk("tod_rsp_err",     32'(bus.rsp_err), 32'h0);
    chk("tod_rsp_rdata",   32'(bus.rsp_rdata), 32'h3C);
    chk("tod_m_abort",     32'(bus.m_abort), 32'h0);
    bus.req = 2'b00;
    tick();
    chk("tod_m_abort_next", 32'(bus.m_abort), 32'h0);
    tick();
    bus.req_rw = 2'b00;
`else
    // Without the watchdog WAIT holds indefinitely
    bus.req = 2'b01;
    tick(3);
    chk("nto_m_start", 32'(bus.m_start), 32'h1);
    tick(40);
    chk("nto_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("nto_m_abort",   32'(bus.m_abort), 32'h0);
    chk("nto_grant",     32'(bus.grant), 32'h1);
    pulse_done(1'b0, 8'h00);
    chk("nto_rsp_valid_done", 32'(bus.rsp_valid), 32'h1);
    chk("nto_rsp_timeout",    32'(bus.rsp_timeout), 32'h0);
    bus.req = 2'b00;
    tick(2);
`endif

    // Reset mid-WAIT; requester 0 went last so requester 1 wins first
    bus.req = 2'b11;
    tick(3);
    chk("mr_m_start",   32'(bus.m_start), 32'h1);
    chk("mr_grant_pre", 32'(bus.grant), 32'h2);
    tick(5);
    chk("mr_grant_wait", 32'(bus.grant), 32'h2);
    reset_n = 1'b0;
    #1;
    chk("mr_grant_rst",     32'(bus.grant), 32'h0);
    chk("mr_m_start_rst",   32'(bus.m_start), 32'h0);
    chk("mr_rsp_valid_rst", 32'(bus.rsp_valid), 32'h0);
    chk("mr_m_addr_rst",    32'(bus.m_addr), 32'h0);
    tick();
    reset_n = 1'b1;
    tick(2);
    chk("mr_first_grant", 32'(bus.grant), 32'h1);
    tick();
    chk("mr_first_m_start", 32'(bus.m_start), 32'h1);
    tick();
    pulse_done(1'b0, 8'h00);
    chk("mr_rsp_id", 32'(bus.rsp_id), 32'h0);
    bus.req = 2'b00;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
